// File: rtl/r_type_exec_seq.sv
// Sequenced RV32I R-type execute unit: single-cycle ALU ops, SLL/SRL/SRA
// through an iterative shifter that moves at most SHIFT_STEP bits per cycle.
module r_type_exec_seq #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     idata,
  input  logic [XLEN-1:0] rv1,
  input  logic [XLEN-1:0] rv2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic [4:0]      rd_addr,
  output logic            illegal,
  output logic            busy
);

  localparam logic [4:0] K_ADD  = 5'b0_0_000;
  localparam logic [4:0] K_SUB  = 5'b1_0_000;
  localparam logic [4:0] K_SLL  = 5'b0_0_001;
  localparam logic [4:0] K_SLT  = 5'b0_0_010;
  localparam logic [4:0] K_SLTU = 5'b0_0_011;
  localparam logic [4:0] K_XOR  = 5'b0_0_100;
  localparam logic [4:0] K_SRL  = 5'b0_0_101;
  localparam logic [4:0] K_SRA  = 5'b1_0_101;
  localparam logic [4:0] K_OR   = 5'b0_0_110;
  localparam logic [4:0] K_AND  = 5'b0_0_111;
  localparam logic [4:0] STEP   = 5'(SHIFT_STEP);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_L, SH_RL, SH_RA} sop_t;

  state_t          state;
  sop_t            sop, sop_n;
  logic [4:0]      rem, amt, key, shamt;
  logic [XLEN-1:0] alu_res, shifted;
  logic            alu_ill, is_shift;
  logic            unused_idata;

  assign key          = {idata[30], idata[25], idata[14:12]};
  assign shamt        = rv2[4:0];
  assign unused_idata = ^{idata[31], idata[29:26], idata[24:15], idata[6:0]};

  // Shift ops load rv1 as the starting value so shamt=0 completes directly.
  always_comb begin
    alu_res  = '0;
    alu_ill  = 1'b0;
    is_shift = 1'b0;
    sop_n    = SH_L;
    case (key)
      K_ADD:  alu_res = rv1 + rv2;
      K_SUB:  alu_res = rv1 - rv2;
      K_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rv1) < $signed(rv2)};
      K_SLTU: alu_res = {{(XLEN-1){1'b0}}, rv1 < rv2};
      K_XOR:  alu_res = rv1 ^ rv2;
      K_OR:   alu_res = rv1 | rv2;
      K_AND:  alu_res = rv1 & rv2;
      K_SLL:  begin alu_res = rv1; is_shift = 1'b1; sop_n = SH_L;  end
      K_SRL:  begin alu_res = rv1; is_shift = 1'b1; sop_n = SH_RL; end
      K_SRA:  begin alu_res = rv1; is_shift = 1'b1; sop_n = SH_RA; end
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    amt = (rem < STEP) ? rem : STEP;
    case (sop)
      SH_L:    shifted = rd_data << amt;
      SH_RL:   shifted = rd_data >> amt;
      default: shifted = $unsigned($signed(rd_data) >>> amt);
    endcase
  end

  // rd_data doubles as the shift accumulator while in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rd_data   <= '0;
      rd_addr   <= '0;
      illegal   <= 1'b0;
      busy      <= 1'b0;
      rem       <= '0;
      sop       <= SH_L;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          rd_addr  <= idata[11:7];
          illegal  <= alu_ill;
          sop      <= sop_n;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (is_shift && shamt != 5'd0) begin
            state   <= SHIFT;
            rem     <= shamt;
            rd_data <= rv1;
          end else begin
            state     <= DONE;
            rd_data   <= alu_res;
            out_valid <= 1'b1;
          end
        end
        SHIFT: begin
          rd_data <= shifted;
          rem     <= rem - amt;
          if (rem == amt) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_r_type_exec_seq.sv
// Bench for r_type_exec_seq: directed ops with literal expectations plus a
// latency/result model compared against the outputs every cycle.
module tb_r_type_exec_seq;
  localparam int STEP = 1;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready, illegal, busy;
  logic [31:0] idata, rv1, rv2, rd_data;
  logic [4:0]  rd_addr;
  int          tests = 0, fails = 0;
  logic        chk_en = 1'b0;

  r_type_exec_seq #(.XLEN(32), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .idata(idata), .rv1(rv1), .rv2(rv2), .out_valid(out_valid),
    .out_ready(out_ready), .rd_data(rd_data), .rd_addr(rd_addr),
    .illegal(illegal), .busy(busy));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: result and cycles from accept to out_valid
  typedef struct packed { logic [31:0] res; logic ill; logic [7:0] lat; } mres_t;

  function automatic mres_t mres(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    mres_t r;
    logic [4:0] k;
    int sh;
    k = {ins[30], ins[25], ins[14:12]};
    sh = int'(b[4:0]);
    r.res = 32'd0; r.ill = 1'b0; r.lat = 8'd1;
    case (k)
      5'b00000: r.res = a + b;
      5'b10000: r.res = a - b;
      5'b00001: r.res = a << sh;
      5'b00010: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'b00011: r.res = (a < b) ? 32'd1 : 32'd0;
      5'b00100: r.res = a ^ b;
      5'b00101: r.res = a >> sh;
      5'b10101: r.res = $unsigned($signed(a) >>> sh);
      5'b00110: r.res = a | b;
      5'b00111: r.res = a & b;
      default:  r.ill = 1'b1;
    endcase
    if ((k == 5'b00001 || k == 5'b00101 || k == 5'b10101) && sh != 0)
      r.lat = 8'(1 + (sh + STEP - 1) / STEP);
    return r;
  endfunction

  mres_t      mnext, m_cur;
  logic       m_idle, m_valid;
  logic [4:0] m_addr;
  int         m_wait;

  assign mnext = mres(idata, rv1, rv2);

  always @(posedge clk) begin
    if (reset) begin
      m_idle <= 1'b1; m_valid <= 1'b0; m_wait <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_cur   <= mnext;
        m_addr  <= idata[11:7];
        m_idle  <= 1'b0;
        m_wait  <= int'(mnext.lat) - 1;
        m_valid <= (mnext.lat == 8'd1);
      end
    end else if (!m_valid) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (out_ready) begin
      m_valid <= 1'b0; m_idle <= 1'b1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("mdl_in_ready",  {31'd0, in_ready},  {31'd0, m_idle});
    chk("mdl_busy",      {31'd0, busy},      {31'd0, !m_idle});
    if (m_valid) begin
      chk("mdl_rd_data", rd_data, m_cur.res);
      chk("mdl_rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
      chk("mdl_illegal", {31'd0, illegal}, {31'd0, m_cur.ill});
    end
  end

  function automatic logic [31:0] mk(input logic b30, input logic b25, input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, b30, 4'b0000, b25, 10'd0, f3, rd, 7'b0110011};
  endfunction

  task automatic run_op(input string nm, input logic b30, input logic b25, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic eill, input int elat, input int hold);
    int n;
    @(negedge clk);
    chk({nm, "_in_ready_pre"}, {31'd0, in_ready}, 32'd1);
    idata = mk(b30, b25, f3, rd); rv1 = a; rv2 = b;
    in_valid = 1'b1; out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0; idata = $urandom; rv1 = $urandom; rv2 = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_rd_data"}, rd_data, exp);
    chk({nm, "_rd_addr"}, {27'd0, rd_addr}, {27'd0, rd});
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, eill});
    for (int i = 0; i < hold; i++) begin
      chk({nm, "_hold_in_ready"},  {31'd0, in_ready},  32'd0);
      chk({nm, "_hold_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({nm, "_hold_rd_data"},   rd_data, exp);
      chk({nm, "_hold_rd_addr"},   {27'd0, rd_addr}, {27'd0, rd});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_post_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_post_in_ready"},  {31'd0, in_ready},  32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    idata = 32'd0; rv1 = 32'd0; rv2 = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rd_data",   rd_data, 32'd0);
    chk("rst_rd_addr",   {27'd0, rd_addr}, 32'd0);
    chk("rst_illegal",   {31'd0, illegal}, 32'd0);
    chk("rst_busy",      {31'd0, busy},    32'd0);
    chk_en = 1'b1;
    reset = 1'b0;

    run_op("add",  0, 0, 3'b000, 5'd5,  32'd415,      32'd60, 32'd475,      0, 1,  0);
    run_op("sub",  1, 0, 3'b000, 5'd9,  32'd6553,     32'd653, 32'd5900,    0, 1,  0);
    run_op("slt",  0, 0, 3'b010, 5'd1,  32'hFFFFFFFF, 32'd1,  32'd1,        0, 1,  0);
    run_op("sltu", 0, 0, 3'b011, 5'd2,  32'hFFFFFFFF, 32'd1,  32'd0,        0, 1,  0);
    run_op("xor",  0, 0, 3'b100, 5'd3,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 0, 1, 0);
    run_op("or",   0, 0, 3'b110, 5'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 0, 1, 0);
    run_op("and",  0, 0, 3'b111, 5'd6,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 1, 0);
    run_op("sll29",0, 0, 3'b001, 5'd7,  32'd288,      32'd349, 32'd0,       0, 30, 0);
    run_op("sra4", 1, 0, 3'b101, 5'd8,  32'h80000000, 32'd4,  32'hF8000000, 0, 5,  0);
    run_op("srl4", 0, 0, 3'b101, 5'd10, 32'h80000000, 32'd4,  32'h08000000, 0, 5,  0);
    run_op("sra3p",1, 0, 3'b101, 5'd11, 32'h70000000, 32'd3,  32'h0E000000, 0, 4,  0);
    run_op("srl0", 0, 0, 3'b101, 5'd12, 32'h12345678, 32'd32, 32'h12345678, 0, 1,  0);
    run_op("bp",   0, 0, 3'b000, 5'd13, 32'd1,        32'd2,  32'd3,        0, 1,  3);
    run_op("ill",  0, 1, 3'b000, 5'd14, 32'd100,      32'd200, 32'd0,       1, 1,  0);

    // Reset in the middle of a long shift must drop the result.
    @(negedge clk);
    idata = mk(0, 0, 3'b001, 5'd15); rv1 = 32'd288; rv2 = 32'd29; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rstmid_busy",      {31'd0, busy},      32'd0);
    chk("rstmid_rd_data",   rd_data, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("rstmid_no_stale", {31'd0, out_valid}, 32'd0);

    run_op("add_after", 0, 0, 3'b000, 5'd31, 32'hFFFFFFFF, 32'd2, 32'd1, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
